// File: rtl/fft_pkg.sv
// Shared fixed-point definitions for the FFT datapath: default Q-format,
// complex sample type, and the round/saturate helpers used by every stage.
`default_nettype none

package fft_pkg;

  localparam int I_DEF = 1;
  localparam int F_DEF = 15;
  localparam int W_DEF = I_DEF + F_DEF;

  typedef struct packed {
    logic signed [W_DEF-1:0] re;
    logic signed [W_DEF-1:0] im;
  } cplx_t;

  // Wide working type; comfortably holds a 2W+1-bit product for W up to 31.
  typedef logic signed [63:0] acc_t;

  // Round half-up then arithmetic shift right; sh must be at least 1.
  function automatic acc_t round_shift(input acc_t x, input int sh);
    acc_t bias;
    bias = acc_t'(1) <<< (sh - 1);
    return (x + bias) >>> sh;
  endfunction

  function automatic acc_t saturate(input acc_t x, input int w);
    acc_t hi;
    acc_t lo;
    hi = (acc_t'(1) <<< (w - 1)) - acc_t'(1);
    lo = -(acc_t'(1) <<< (w - 1));
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

endpackage

`default_nettype wire

// File: rtl/radix2_butterfly_if.sv
// Data bundle of the radix-2 butterfly: operand inputs and result outputs.
// Element [0] of every pair is the real part, [1] the imaginary part.
`default_nettype none

interface radix2_butterfly_if #(
  parameter int W = fft_pkg::W_DEF
);
  logic signed [W-1:0] i_even [0:1];
  logic signed [W-1:0] i_odd  [0:1];
  logic signed [W-1:0] i_twi  [0:1];
  logic signed [W-1:0] o_top  [0:1];
  logic signed [W-1:0] o_btm  [0:1];

  modport master (
    output i_even, i_odd, i_twi,
    input  o_top, o_btm
  );

  modport slave (
    input  i_even, i_odd, i_twi,
    output o_top, o_btm
  );
endinterface

`default_nettype wire

// File: rtl/complex_multiplier.sv
// Registered complex multiply p = a*b with half-up rounding of the Q-format
// product and saturation to W bits; one cycle of latency, gated by i_en.
`default_nettype none

module complex_multiplier
  import fft_pkg::*;
#(
  parameter int I = I_DEF,
  parameter int F = F_DEF,
  localparam int W = I + F
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic signed [W-1:0] i_a [0:1],
  input  logic signed [W-1:0] i_b [0:1],
  output logic signed [W-1:0] o_p [0:1]
);

  acc_t a_x [0:1];
  acc_t b_x [0:1];
  acc_t prod_re;
  acc_t prod_im;
  acc_t sat_re;
  acc_t sat_im;
  logic signed [W-1:0] p_d [0:1];
  logic signed [W-1:0] p_q [0:1];
  logic unused_hi;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      a_x[k] = {{(64-W){i_a[k][W-1]}}, i_a[k]};
      b_x[k] = {{(64-W){i_b[k][W-1]}}, i_b[k]};
    end
    prod_re = a_x[0] * b_x[0] - a_x[1] * b_x[1];
    prod_im = a_x[0] * b_x[1] + a_x[1] * b_x[0];
    sat_re  = saturate(round_shift(prod_re, F), W);
    sat_im  = saturate(round_shift(prod_im, F), W);
    p_d = p_q;
    if (i_en) begin
      p_d[0] = sat_re[W-1:0];
      p_d[1] = sat_im[W-1:0];
    end
  end

  // Saturated values are already in range, so the upper bits are pure sign copies.
  assign unused_hi = ^{sat_re[63:W], sat_im[63:W]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      p_q <= '{default: '0};
    end else begin
      p_q <= p_d;
    end
  end

  assign o_p = p_q;

endmodule

`default_nettype wire

// File: rtl/radix2_butterfly.sv
// Two-stage radix-2 DIT butterfly: top = even + odd*twi, btm = even - odd*twi.
// Define BUTTERFLY_SCALE_EN to halve both results (round half-up) before saturation.
`default_nettype none

module radix2_butterfly
  import fft_pkg::*;
#(
  parameter int I = I_DEF,
  parameter int F = F_DEF,
  localparam int W = I + F
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  radix2_butterfly_if.slave     bus
);

  logic signed [W-1:0] odd_w  [0:1];
  logic signed [W-1:0] twi_w  [0:1];
  logic signed [W-1:0] p_w    [0:1];
  logic signed [W-1:0] even_d [0:1];
  logic signed [W-1:0] even_q [0:1];
  logic signed [W-1:0] top_d  [0:1];
  logic signed [W-1:0] top_q  [0:1];
  logic signed [W-1:0] btm_d  [0:1];
  logic signed [W-1:0] btm_q  [0:1];
  acc_t e_x   [0:1];
  acc_t p_x   [0:1];
  acc_t sum_x [0:1];
  acc_t dif_x [0:1];
  acc_t sum_s [0:1];
  acc_t dif_s [0:1];
  logic unused_hi;

  assign odd_w = bus.i_odd;
  assign twi_w = bus.i_twi;

  complex_multiplier #(
    .I (I),
    .F (F)
  ) u_cmul (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (i_en),
    .i_a     (odd_w),
    .i_b     (twi_w),
    .o_p     (p_w)
  );

  always_comb begin
    even_d = even_q;
    top_d  = top_q;
    btm_d  = btm_q;
    for (int k = 0; k < 2; k++) begin
      e_x[k]   = {{(64-W){even_q[k][W-1]}}, even_q[k]};
      p_x[k]   = {{(64-W){p_w[k][W-1]}}, p_w[k]};
      sum_x[k] = e_x[k] + p_x[k];
      dif_x[k] = e_x[k] - p_x[k];
`ifdef BUTTERFLY_SCALE_EN
      sum_x[k] = round_shift(sum_x[k], 1);
      dif_x[k] = round_shift(dif_x[k], 1);
`endif
      sum_s[k] = saturate(sum_x[k], W);
      dif_s[k] = saturate(dif_x[k], W);
      if (i_en) begin
        even_d[k] = bus.i_even[k];
        top_d[k]  = sum_s[k][W-1:0];
        btm_d[k]  = dif_s[k][W-1:0];
      end
    end
  end

  assign unused_hi = ^{sum_s[0][63:W], sum_s[1][63:W], dif_s[0][63:W], dif_s[1][63:W]};

  // Even operand is delayed one stage so it lines up with the registered product.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      even_q <= '{default: '0};
      top_q  <= '{default: '0};
      btm_q  <= '{default: '0};
    end else begin
      even_q <= even_d;
      top_q  <= top_d;
      btm_q  <= btm_d;
    end
  end

  assign bus.o_top = top_q;
  assign bus.o_btm = btm_q;

endmodule

`default_nettype wire

// File: tb/tb_radix2_butterfly.sv
// Directed-vector bench for radix2_butterfly (Q1.15) with hand-computed results.
`default_nettype none

module tb_radix2_butterfly;

  typedef struct {
    int e_re, e_im, o_re, o_im, t_re, t_im;
    int top_re, top_im, btm_re, btm_im;
  } vec_t;

  localparam int N = 8;

  logic clk;
  logic rst_n;
  logic en;
  int   total;
  int   bad;
  vec_t vec [0:N-1];
  vec_t zv;

  radix2_butterfly_if #(.W(16)) bus ();

  radix2_butterfly dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (en),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input vec_t v);
    check({tag, ".top_re"}, int'(bus.o_top[0]), v.top_re);
    check({tag, ".top_im"}, int'(bus.o_top[1]), v.top_im);
    check({tag, ".btm_re"}, int'(bus.o_btm[0]), v.btm_re);
    check({tag, ".btm_im"}, int'(bus.o_btm[1]), v.btm_im);
  endtask

  task automatic apply(input vec_t v);
    bus.i_even[0] = 16'(v.e_re);
    bus.i_even[1] = 16'(v.e_im);
    bus.i_odd[0]  = 16'(v.o_re);
    bus.i_odd[1]  = 16'(v.o_im);
    bus.i_twi[0]  = 16'(v.t_re);
    bus.i_twi[1]  = 16'(v.t_im);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    zv = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`ifdef BUTTERFLY_SCALE_EN
    vec[0] = '{ 16384,     0,   4059,     0,      0,      0,   8192,     0,   8192,     0};
    vec[1] = '{ 16384,     0,   4059,     0,  32767,      0,  10222,     0,   6163,     0};
    vec[2] = '{     0,     0,   8192,     0,      0,  32767,      0,  4096,      0, -4096};
    vec[3] = '{ 32767,     0,  32767,     0,  32767,      0,  32767,     0,      1,     0};
    vec[4] = '{-32768,     0,  32767,     0,  32767,      0,     -1,     0, -32767,     0};
    vec[5] = '{     0,     0, -32768,     0, -32768,      0,  16384,     0, -16383,     0};
    vec[6] = '{     0,     0,      1,     0, -16384,  16384,      0,     1,      0,     0};
    vec[7] = '{  1000, -2000,  16384, 16384,  16384, -16384,   8692, -1000,  -7692, -1000};
`else
    vec[0] = '{ 16384,     0,   4059,     0,      0,      0,  16384,     0,  16384,     0};
    vec[1] = '{ 16384,     0,   4059,     0,  32767,      0,  20443,     0,  12325,     0};
    vec[2] = '{     0,     0,   8192,     0,      0,  32767,      0,  8192,      0, -8192};
    vec[3] = '{ 32767,     0,  32767,     0,  32767,      0,  32767,     0,      1,     0};
    vec[4] = '{-32768,     0,  32767,     0,  32767,      0,     -2,     0, -32768,     0};
    vec[5] = '{     0,     0, -32768,     0, -32768,      0,  32767,     0, -32767,     0};
    vec[6] = '{     0,     0,      1,     0, -16384,  16384,      0,     1,      0,    -1};
    vec[7] = '{  1000, -2000,  16384, 16384,  16384, -16384,  17384, -2000, -15384, -2000};
`endif

    // Held in reset with live inputs and enable: outputs must stay zero.
    rst_n = 1'b0;
    en    = 1'b1;
    apply(vec[1]);
    @(negedge clk);
    @(negedge clk);
    check_out("reset", zv);

    // Release and stream every vector back to back.
    rst_n = 1'b1;
    apply(vec[0]);
    for (int i = 1; i < N + 2; i++) begin
      @(negedge clk);
      if (i == 1) check_out("latency", zv);
      if (i >= 2) check_out($sformatf("vec%0d", i - 2), vec[i - 2]);
      if (i < N) apply(vec[i]);
    end

    // Enable hold: outputs freeze, in-flight sample survives.
    apply(vec[1]);
    @(negedge clk);
    apply(vec[2]);
    @(negedge clk);
    check_out("pre_hold", vec[1]);
    en = 1'b0;
    apply(vec[3]);
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      check_out($sformatf("hold%0d", h), vec[1]);
      apply(vec[4 + h]);
    end
    en = 1'b1;
    apply(vec[7]);
    @(negedge clk);
    check_out("resume0", vec[2]);
    @(negedge clk);
    check_out("resume1", vec[7]);

    // Asynchronous reset between edges with a full pipeline.
    apply(vec[1]);
    @(negedge clk);
    apply(vec[3]);
    @(negedge clk);
    check_out("pre_rst", vec[1]);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_out("async_rst", zv);
    @(negedge clk);
    rst_n = 1'b1;
    apply(vec[2]);
    @(negedge clk);
    check_out("post_rst0", zv);
    @(negedge clk);
    check_out("post_rst1", vec[2]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
